// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store queue: func3 codes, the operand tag
// and entry records, the FSM encoding and small address/length helpers.
package lsq_pkg;

    // Width of the stored ROB position; instances keep ROB_W <= POS_W.
    localparam int POS_W = 8;

    localparam logic [2:0] FUNC3_LB  = 3'b000;
    localparam logic [2:0] FUNC3_LH  = 3'b001;
    localparam logic [2:0] FUNC3_LW  = 3'b010;
    localparam logic [2:0] FUNC3_LBU = 3'b100;
    localparam logic [2:0] FUNC3_LHU = 3'b101;

    // pend = 1: operand still waiting for ROB position pos to broadcast.
    typedef struct packed {
        logic             pend;
        logic [POS_W-1:0] pos;
    } tag_t;

    typedef struct packed {
        logic             valid;
        logic             is_store;
        logic             committed;
        logic [2:0]       func3;
        tag_t             rs1;
        logic [31:0]      rs1_val;
        tag_t             rs2;
        logic [31:0]      rs2_val;
        logic [31:0]      imm;
        logic [POS_W-1:0] rob_pos;
    } entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic is_io(input logic [31:0] addr, input logic [31:0] mask);
        return (addr & mask) == mask;
    endfunction

    function automatic logic [2:0] len_of(input logic [2:0] func3);
        case (func3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsq_ld_ext.sv
// Load data extension: raw LSB-aligned bus data to the architectural value.
module lsq_ld_ext
    import lsq_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    // Sign- or zero-extend according to the access width code.
    always_comb begin
        ext = raw;
        case (func3)
            FUNC3_LB:  ext = {{24{raw[7]}}, raw[7:0]};
            FUNC3_LH:  ext = {{16{raw[15]}}, raw[15:0]};
            FUNC3_LBU: ext = {24'h0, raw[7:0]};
            FUNC3_LHU: ext = {16'h0, raw[15:0]};
            default:   ext = raw;
        endcase
    end

endmodule

// File: rtl/lsq_param.sv
// In-order load/store queue. Entries wait for operands on the wakeup
// channels, the head entry issues one memory access at a time, loads return
// on the result port and stores wait for ROB commit. Rollback keeps only the
// committed stores, which always sit contiguously at the head.
//
// Handshake: mem_req rises with its fields registered and all of them hold
// steady until the single-cycle mem_done pulse; the request drops on the
// edge that samples mem_done, and at most one access is outstanding.
module lsq_param
    import lsq_pkg::*;
#(
    parameter int          DEPTH   = 16,
    parameter int          ROB_W   = 4,
    parameter int          NCDB    = 2,
    parameter logic [31:0] IO_MASK = 32'h0003_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    input  logic                    disp_en,
    input  logic                    disp_is_store,
    input  logic [2:0]              disp_func3,
    input  logic [ROB_W:0]          disp_rs1_tag,
    input  logic [31:0]             disp_rs1_val,
    input  logic [ROB_W:0]          disp_rs2_tag,
    input  logic [31:0]             disp_rs2_val,
    input  logic [31:0]             disp_imm,
    input  logic [ROB_W-1:0]        disp_rob_pos,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [2:0]              mem_len,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_done,
    input  logic [31:0]             mem_rdata,
    input  logic                    rob_commit_st,
    input  logic [ROB_W-1:0]        rob_commit_pos,
    input  logic [ROB_W-1:0]        rob_head_pos,
    input  logic [NCDB-1:0]         cdb_valid,
    input  logic [NCDB*ROB_W-1:0]   cdb_pos,
    input  logic [NCDB*32-1:0]      cdb_val,
    output logic                    res_valid,
    output logic [ROB_W-1:0]        res_rob_pos,
    output logic [31:0]             res_val,
    output logic                    dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d, ncommit_q, ncommit_d;
    state_t           state_q, state_d;
    logic             drop_q, drop_d;
    logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [2:0]       mem_len_q, mem_len_d;
    logic             fl_store_q, fl_store_d;
    logic [2:0]       fl_func3_q, fl_func3_d;
    logic [ROB_W-1:0] fl_pos_q, fl_pos_d;
    logic             res_valid_q, res_valid_d;
    logic [ROB_W-1:0] res_rob_pos_q, res_rob_pos_d;
    logic [31:0]      res_val_q, res_val_d;

    logic [31:0]      head_addr;
    logic             issue_ok;
    logic [31:0]      ext_val;
    entry_t           new_ent;
    logic             commit_hit, pop, skip, do_disp;

    lsq_ld_ext u_ext (
        .func3 (fl_func3_q),
        .raw   (mem_rdata),
        .ext   (ext_val)
    );

    assign head_addr = ent_q[head_q].rs1_val + ent_q[head_q].imm;
    assign issue_ok  = ent_q[head_q].valid && !ent_q[head_q].rs1.pend && !ent_q[head_q].rs2.pend &&
                       (ent_q[head_q].is_store ? ent_q[head_q].committed :
                        (!rollback && (!is_io(head_addr, IO_MASK) ||
                                       ent_q[head_q].rob_pos == POS_W'(rob_head_pos))));

    // Next state: wakeup, commit, issue/complete FSM, pop, dispatch, rollback.
    always_comb begin
        ent_d         = ent_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        state_d       = state_q;
        drop_d        = drop_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_len_d     = mem_len_q;
        mem_wdata_d   = mem_wdata_q;
        fl_store_d    = fl_store_q;
        fl_func3_d    = fl_func3_q;
        fl_pos_d      = fl_pos_q;
        res_valid_d   = 1'b0;
        res_rob_pos_d = res_rob_pos_q;
        res_val_d     = res_val_q;
        commit_hit    = 1'b0;
        pop           = 1'b0;
        skip          = 1'b0;
        do_disp       = rdy && disp_en && !rollback;
        new_ent       = '0;

        if (rdy) begin
            // Wakeup; scanning channels downwards lets the lowest index win.
            for (int i = 0; i < DEPTH; i++) begin
                for (int k = NCDB - 1; k >= 0; k--) begin
                    if (cdb_valid[k] && ent_q[i].valid && ent_q[i].rs1.pend &&
                        ent_q[i].rs1.pos == POS_W'(cdb_pos[k*ROB_W +: ROB_W])) begin
                        ent_d[i].rs1.pend = 1'b0;
                        ent_d[i].rs1_val  = cdb_val[k*32 +: 32];
                    end
                    if (cdb_valid[k] && ent_q[i].valid && ent_q[i].rs2.pend &&
                        ent_q[i].rs2.pos == POS_W'(cdb_pos[k*ROB_W +: ROB_W])) begin
                        ent_d[i].rs2.pend = 1'b0;
                        ent_d[i].rs2_val  = cdb_val[k*32 +: 32];
                    end
                end
            end

            for (int i = 0; i < DEPTH; i++) begin
                if (rob_commit_st && !commit_hit && ent_q[i].valid && ent_q[i].is_store &&
                    !ent_q[i].committed && ent_q[i].rob_pos == POS_W'(rob_commit_pos)) begin
                    ent_d[i].committed = 1'b1;
                    commit_hit         = 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (issue_ok) begin
                        state_d     = ST_BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ent_q[head_q].is_store;
                        mem_addr_d  = head_addr;
                        mem_len_d   = len_of(ent_q[head_q].func3);
                        mem_wdata_d = ent_q[head_q].rs2_val;
                        fl_store_d  = ent_q[head_q].is_store;
                        fl_func3_d  = ent_q[head_q].func3;
                        fl_pos_d    = ROB_W'(ent_q[head_q].rob_pos);
                    end
                end
                ST_BUSY: begin
                    if (mem_done) begin
                        state_d   = ST_IDLE;
                        mem_req_d = 1'b0;
                        if (drop_q) begin
                            // Flushed load: its slot was already released at rollback.
                            drop_d = 1'b0;
                        end else begin
                            pop = 1'b1;
                            if (!fl_store_q && !rollback) begin
                                res_valid_d   = 1'b1;
                                res_rob_pos_d = fl_pos_q;
                                res_val_d     = ext_val;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (pop) begin
                ent_d[head_q].valid = 1'b0;
                head_d              = head_q + 1'b1;
            end

            if (do_disp) begin
                new_ent.valid     = 1'b1;
                new_ent.is_store  = disp_is_store;
                new_ent.committed = 1'b0;
                new_ent.func3     = disp_func3;
                new_ent.rs1.pend  = disp_rs1_tag[ROB_W];
                new_ent.rs1.pos   = POS_W'(disp_rs1_tag[ROB_W-1:0]);
                new_ent.rs1_val   = disp_rs1_val;
                new_ent.rs2.pend  = disp_rs2_tag[ROB_W];
                new_ent.rs2.pos   = POS_W'(disp_rs2_tag[ROB_W-1:0]);
                new_ent.rs2_val   = disp_rs2_val;
                new_ent.imm       = disp_imm;
                new_ent.rob_pos   = POS_W'(disp_rob_pos);
                // Same-cycle broadcast is captured at dispatch.
                for (int k = NCDB - 1; k >= 0; k--) begin
                    if (cdb_valid[k] && disp_rs1_tag[ROB_W] &&
                        disp_rs1_tag[ROB_W-1:0] == cdb_pos[k*ROB_W +: ROB_W]) begin
                        new_ent.rs1.pend = 1'b0;
                        new_ent.rs1_val  = cdb_val[k*32 +: 32];
                    end
                    if (cdb_valid[k] && disp_rs2_tag[ROB_W] &&
                        disp_rs2_tag[ROB_W-1:0] == cdb_pos[k*ROB_W +: ROB_W]) begin
                        new_ent.rs2.pend = 1'b0;
                        new_ent.rs2_val  = cdb_val[k*32 +: 32];
                    end
                end
                ent_d[tail_q] = new_ent;
                tail_d        = tail_q + 1'b1;
            end

            count_d = count_q + CNT_W'(do_disp) - CNT_W'(pop);
        end

        ncommit_d = ncommit_q + CNT_W'(commit_hit) - CNT_W'(pop && fl_store_q);

        if (rollback) begin
            // An in-flight load keeps its bus access but gives up its slot now.
            skip = (state_q == ST_BUSY) && !fl_store_q && !drop_q && !pop;
            for (int i = 0; i < DEPTH; i++) begin
                if (!ent_d[i].committed) ent_d[i].valid = 1'b0;
            end
            if (skip) begin
                ent_d[head_d].valid = 1'b0;
                drop_d              = 1'b1;
                head_d              = head_d + 1'b1;
            end
            tail_d  = head_d + PTR_W'(ncommit_d);
            count_d = ncommit_d;
        end
    end

    // State and output registers; reset drops any request immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q         <= '{default: '0};
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            ncommit_q     <= '0;
            state_q       <= ST_IDLE;
            drop_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_len_q     <= '0;
            mem_wdata_q   <= '0;
            fl_store_q    <= 1'b0;
            fl_func3_q    <= '0;
            fl_pos_q      <= '0;
            res_valid_q   <= 1'b0;
            res_rob_pos_q <= '0;
            res_val_q     <= '0;
        end else begin
            ent_q         <= ent_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            ncommit_q     <= ncommit_d;
            state_q       <= state_d;
            drop_q        <= drop_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_len_q     <= mem_len_d;
            mem_wdata_q   <= mem_wdata_d;
            fl_store_q    <= fl_store_d;
            fl_func3_q    <= fl_func3_d;
            fl_pos_q      <= fl_pos_d;
            res_valid_q   <= res_valid_d;
            res_rob_pos_q <= res_rob_pos_d;
            res_val_q     <= res_val_d;
        end
    end

    // Dispatching into a completely full queue is a protocol error upstream.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(rdy && disp_en && !rollback && count_q == CNT_W'(DEPTH)));

    assign full        = count_q >= CNT_W'(DEPTH - 1);
    assign count       = count_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_len     = mem_len_q;
    assign mem_wdata   = mem_wdata_q;
    assign res_valid   = res_valid_q;
    assign res_rob_pos = res_rob_pos_q;
    assign res_val     = res_val_q;
    assign dbg_state   = state_q;

endmodule
